conv_pixel_feeder: RTL

Double-buffered frame source that drives the raster pixel stream into the first convolution layer's 5x5 window buffer. A host or loader writes one WIDTH x HEIGHT image at a time in raster order into a ping-pong frame store. The block then transmits each completed frame as a contiguous raster stream, one pixel per transfer, with valid/ready flow control and frame-boundary markers. It is the transmit end of the pixel interface that the window buffer consumes.

---
 rtl/conv_pixel_feeder_if.sv | 26 ++
 rtl/conv_pixel_feeder.sv | 137 +++++++++++++
 2 files changed

// File: rtl/conv_pixel_feeder_if.sv
// Pixel feeder port bundle: loader write side plus the raster stream toward the window buffer.
interface conv_pixel_feeder_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 wr_en;
  logic [DATA_BITS-1:0] wr_data;
  logic                 wr_ready;
  logic                 overflow;
  logic                 out_ready;
  logic [DATA_BITS-1:0] data_out;
  logic                 valid_out;
  logic                 frame_start;
  logic                 frame_done;

  // Feeder side: accepts loader writes, transmits the stream.
  modport master (
    input  wr_en, wr_data, out_ready,
    output wr_ready, overflow, data_out, valid_out, frame_start, frame_done
  );

  // Environment side: loader and downstream consumer.
  modport slave (
    output wr_en, wr_data, out_ready,
    input  wr_ready, overflow, data_out, valid_out, frame_start, frame_done
  );
endinterface

// File: rtl/conv_pixel_feeder.sv
// Ping-pong frame store: one bank fills from the loader while the other streams out in raster
// order with valid/ready flow control and frame_start/frame_done markers.
module conv_pixel_feeder #(
  parameter int unsigned WIDTH     = 28,
  parameter int unsigned HEIGHT    = 28,
  parameter int unsigned DATA_BITS = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  conv_pixel_feeder_if.master  pix
);

  localparam int unsigned NPIX = WIDTH * HEIGHT;
  localparam int unsigned AW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);

  typedef enum logic [0:0] {StIdle, StStream} state_e;

  logic [DATA_BITS-1:0] mem [2][NPIX];

  logic [1:0]           full_q, full_d;
  logic                 wr_bank_q, rd_bank_q;
  logic [AW-1:0]        wr_addr_q, rd_addr_q;
  state_e               state_q, state_d;
  logic                 overflow_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q, start_q, done_q;

  logic wr_ready, wr_fire, wr_last;
  logic can_load, rd_load, rd_last;

  assign wr_ready = ~full_q[wr_bank_q];
  assign wr_fire  = pix.wr_en && wr_ready;
  assign wr_last  = (wr_addr_q == LAST_ADDR);
  assign can_load = !valid_q || pix.out_ready;
  assign rd_last  = (rd_addr_q == LAST_ADDR);

  // Frame store write port; contents are never reset and never read before rewritten.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_bank_q][wr_addr_q] <= pix.wr_data;
  end

  // Write address/bank pointer and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr_q  <= '0;
      wr_bank_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_fire) begin
        if (wr_last) begin
          wr_addr_q <= '0;
          wr_bank_q <= ~wr_bank_q;
        end else begin
          wr_addr_q <= wr_addr_q + 1'b1;
        end
      end
      if (pix.wr_en && !wr_ready) overflow_q <= 1'b1;
    end
  end

  // Full flags: writer sets its bank, reader clears its bank; both may land in one cycle.
  always_comb begin
    full_d = full_q;
    if (wr_fire && wr_last) full_d[wr_bank_q] = 1'b1;
    if (rd_load && rd_last) full_d[rd_bank_q] = 1'b0;
  end

  // Full flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) full_q <= '0;
    else        full_q <= full_d;
  end

  // Read FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Read FSM next state: after the last pixel, continue only if the other bank is ready.
  always_comb begin
    state_d = state_q;
    if (rd_load) state_d = (rd_last && !full_q[~rd_bank_q]) ? StIdle : StStream;
  end

  // Read FSM outputs: IDLE loads pixel 0 itself so a waiting frame starts without a bubble.
  always_comb begin
    rd_load = 1'b0;
    unique case (state_q)
      StIdle:   rd_load = can_load && full_q[rd_bank_q];
      StStream: rd_load = can_load;
    endcase
  end

  // Read address and bank pointer advance on every load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr_q <= '0;
      rd_bank_q <= 1'b0;
    end else if (rd_load) begin
      if (rd_last) begin
        rd_addr_q <= '0;
        rd_bank_q <= ~rd_bank_q;
      end else begin
        rd_addr_q <= rd_addr_q + 1'b1;
      end
    end
  end

  // Output register: markers travel with the pixel and hold during a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
    end else if (rd_load) begin
      data_q  <= mem[rd_bank_q][rd_addr_q];
      valid_q <= 1'b1;
      start_q <= (rd_addr_q == '0);
      done_q  <= rd_last;
    end else if (pix.out_ready) begin
      valid_q <= 1'b0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
    end
  end

  assign pix.wr_ready    = wr_ready;
  assign pix.overflow    = overflow_q;
  assign pix.data_out    = data_q;
  assign pix.valid_out   = valid_q;
  assign pix.frame_start = start_q;
  assign pix.frame_done  = done_q;

endmodule
